regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port between NUM_REQ writeback sources
//  (req 0 = ALU writeback, req 1 = load/memory writeback).
//  Round-robin grants, one per cycle; winner registered into a one-entry output stage.
//  The output stage drives RegisterFile WriteReg/DstReg/DstData.
//  pend_mask lets decode stall on a register whose write has not yet landed.
// PARAMETERS
//  NUM_REQ     2   number of writeback requesters (arbitration logic sized for 2..4)
//  DATA_W      16  register data width
//  REG_ADDR_W  4   register index width (16 registers, R0 hardwired zero)
// PORTS
//  clk        in   1                   single clock, all state updates on posedge
//  rst        in   1                   synchronous, active-low: rst==0 at posedge resets
//  req_valid  in   NUM_REQ             requester i presents a write
//  req_dst    in   NUM_REQ*REG_ADDR_W  packed dst index, requester i at [i*4 +: 4]
//  req_data   in   NUM_REQ*DATA_W      packed write data, requester i at [i*16 +: 16]
//  req_ready  out  NUM_REQ             one-hot grant; write consumed at edge when valid&ready
//  wb_stall   in   1                   freeze: no grants, output stage held, WriteReg=0
//  WriteReg   out  1                   to RegisterFile write enable
//  DstReg     out  REG_ADDR_W          to RegisterFile write index
//  DstData    out  DATA_W              to RegisterFile write data
//  pend_mask  out  16                  bit r set: write to Rr held in output stage
// BEHAVIOUR
//  Reset (rst==0 at posedge):
//   - out_vld=0, DstReg=0, DstData=0, WriteReg=0, pend_mask=0.
//   - rr_ptr=NUM_REQ-1, so req 0 has first priority.
//   - A transfer in flight is discarded; req_ready is 0 during reset.
//  Arbitration (combinational, when rst==1 and wb_stall==0):
//   - Search starts at rr_ptr+1 mod NUM_REQ; first valid requester gets req_ready=1.
//   - At most one req_ready high; req_ready never depends on the requester's own ready.
//   - On grant, rr_ptr <= granted index; with no valid request, rr_ptr holds.
//  Output stage: accepted write registered at edge N.
//   - WriteReg=1 during cycle N..N+1; RegisterFile writes at edge N+1.
//   - Source-to-regfile latency: 2 edges. Throughput: 1 write/cycle.
//   - Stage reloads every unstalled cycle; out_vld=0 when nothing granted.
//  R0 writes: requester is granted and consumed normally.
//   - Stage loads with out_vld=0, so WriteReg stays 0 and the pend_mask bit stays clear.
//  wb_stall==1:
//   - All req_ready=0; stage contents and rr_ptr hold; WriteReg forced 0.
//   - A held write issues on the first cycle after stall deasserts; no re-grant occurs.
//  Simultaneous requests to the same register:
//   - Granted in round-robin order, one per cycle; last accepted wins in the regfile.
//  pend_mask = out_vld ? (1<<DstReg) : 0, bit 0 forced 0. Combinational from stage registers.
//  Requester must hold valid/dst/data stable until granted; the arbiter never drops a granted write.
//  WriteReg = out_vld & ~wb_stall. DstReg/DstData always reflect stage contents.
// STRUCTURE
//  Shared package rf_pkg:
//   - REG_ADDR_W, DATA_W, NUM_REGS=16 constants.
//   - typedef rf_wr_t {logic [3:0] dst; logic [15:0] data;}.
//  Sub-module rr_arbiter: NUM_REQ-wide round-robin grant (req, ptr -> one-hot gnt, idx).
//   - Holds no state; rr_ptr register lives in the top module.
//  The top module holds rr_ptr, output-stage registers and pend_mask decode.
// TESTING (bench instantiates RegisterFile behind the arbiter; check via SrcData reads)
//  Reset:
//   - Hold rst=0 two cycles with req_valid=2'b11.
//   - Expect req_ready=0, WriteReg=0, pend_mask=0, R1..R15 read 16'h0000.
//  Single write:
//   - req0 dst=1 data=16'h2A59 one cycle.
//   - Expect req_ready=01, WriteReg=1 next cycle, pend_mask=16'h0002.
//   - R1 reads 16'h2A59 after following edge.
//  Contention:
//   - req0 dst=2 data=16'h1111 and req1 dst=3 data=16'h2222 held valid.
//   - Expect grants 01 then 10, then R2=16'h1111, R3=16'h2222.
//   - Both held 4 cycles -> grants alternate 01,10,01,10.
//  Same register:
//   - req0 dst=4 data=16'hAAAA and req1 dst=4 data=16'hBBBB both valid, rr_ptr=1.
//   - Expect req0 first, then req1; R4 finally reads 16'hBBBB.
//  R0 write:
//   - req1 dst=0 data=16'hFFFF.
//   - Expect req_ready=10, WriteReg stays 0, pend_mask=0, R0 reads 16'h0000.
//  Stall and reset mid-op:
//   - Stall: grant dst=5 data=16'h0505, then wb_stall=1 for 3 cycles.
//   - Expect WriteReg=0, req_ready=0, pend_mask=16'h0020 held; R5 written one edge after release.
//   - Reset mid-op: repeat, assert rst=0 during the stall.
//   - Expect R5 is never written and pend_mask clears.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and write-record type for the register-file writeback path.
// Also provides the pending-register one-hot decode used by decode-stage stall logic.
package rf_pkg;

  localparam int REG_ADDR_W = 4;
  localparam int DATA_W     = 16;
  localparam int NUM_REGS   = 16;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dst;
    logic [DATA_W-1:0]     data;
  } rf_wr_t;

  // R0 is hardwired zero, so its bit never reports a pending write
  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic vld,
                                                     input logic [REG_ADDR_W-1:0] r);
    logic [NUM_REGS-1:0] m;
    m = {NUM_REGS{1'b0}};
    if (vld) begin
      m[r] = 1'b1;
    end else begin
      m = {NUM_REGS{1'b0}};
    end
    m[0] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Stateless round-robin grant: search begins one past ptr and wraps.
// Produces a one-hot grant, the granted index and an any-grant flag.
module rr_arbiter #(
  parameter int N     = 2,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int j;

  // first valid requester after ptr wins
  always_comb begin
    gnt = {N{1'b0}};
    idx = {IDX_W{1'b0}};
    any = 1'b0;
    j   = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        gnt[j] = 1'b1;
        idx    = IDX_W'(j);
        any    = 1'b1;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's single write port among NUM_REQ writeback sources.
// Round-robin grant per cycle into a one-entry output stage feeding the RegisterFile.
module regfile_wb_arbiter
  import rf_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*REG_ADDR_W-1:0] req_dst,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic                         wb_stall,
  output logic                         WriteReg,
  output logic [REG_ADDR_W-1:0]        DstReg,
  output logic [DATA_W-1:0]            DstData,
  output logic [NUM_REGS-1:0]          pend_mask
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   gnt_idx;
  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] gnt;
  logic               gnt_any;
  logic               grant_en;
  logic               out_vld;
  rf_wr_t             sel;
  rf_wr_t             stage;

  // grants are suppressed while in reset or stalled
  assign grant_en = rst & ~wb_stall;
  assign arb_req  = req_valid & {NUM_REQ{grant_en}};

  rr_arbiter #(.N(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req (arb_req),
    .ptr (rr_ptr),
    .gnt (gnt),
    .idx (gnt_idx),
    .any (gnt_any)
  );

  assign req_ready = gnt;

  // mux the granted requester's write record
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel.dst  = req_dst[i*REG_ADDR_W +: REG_ADDR_W];
        sel.data = req_data[i*DATA_W +: DATA_W];
      end else begin
        sel = sel;
      end
    end
  end

  // output stage and round-robin pointer; R0 writes are consumed but never issued
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_vld <= 1'b0;
      stage   <= '0;
      rr_ptr  <= IDX_W'(NUM_REQ - 1);
    end else if (!wb_stall) begin
      if (gnt_any) begin
        out_vld <= (sel.dst != {REG_ADDR_W{1'b0}});
        stage   <= sel;
        rr_ptr  <= gnt_idx;
      end else begin
        out_vld <= 1'b0;
        stage   <= stage;
        rr_ptr  <= rr_ptr;
      end
    end else begin
      out_vld <= out_vld;
      stage   <= stage;
      rr_ptr  <= rr_ptr;
    end
  end

  assign WriteReg  = out_vld & ~wb_stall;
  assign DstReg    = stage.dst;
  assign DstData   = stage.data;
  assign pend_mask = reg_onehot(out_vld, stage.dst);

endmodule
